// File: rtl/lut_checker_multi_if.sv
// Sample/result bus between a bench driver and lut_checker_multi.
// The master side supplies beats; the slave side returns classification and statistics.
interface lut_checker_multi_if #(
  parameter int NCH  = 4,
  parameter int WD   = 16,
  parameter int WCNT = 16,
  parameter int WCH  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic                  in_valid;
  logic [NCH*WD-1:0]     exp_data;
  logic [NCH*WD-1:0]     res_data;
  logic                  out_valid;
  logic [NCH-1:0]        war;
  logic [NCH-1:0]        err;
  logic [NCH*(WD+1)-1:0] min_delta;
  logic [NCH*(WD+1)-1:0] max_delta;
  logic [WCNT-1:0]       smp_cnt;
  logic [WCNT-1:0]       war_cnt;
  logic [WCNT-1:0]       err_cnt;
  logic [WCH-1:0]        first_err_ch;
  logic [WCNT-1:0]       first_err_smp;
  logic                  halted;

  modport master (
    output in_valid, exp_data, res_data,
    input  out_valid, war, err, min_delta, max_delta,
           smp_cnt, war_cnt, err_cnt, first_err_ch, first_err_smp, halted
  );

  modport slave (
    input  in_valid, exp_data, res_data,
    output out_valid, war, err, min_delta, max_delta,
           smp_cnt, war_cnt, err_cnt, first_err_ch, first_err_smp, halted
  );
endinterface

// File: rtl/lut_checker_multi.sv
// Multi-channel expected/obtained comparator: 2-stage pipeline classifying each channel as
// match/warning/error, with saturating statistics, min/max delta and first-error capture.
module lut_checker_multi #(
  parameter int NCH  = 4,
  parameter int WD   = 16,
  parameter int TOL  = 1,
  parameter int WCNT = 16,
  parameter int WCH  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic clk,
  input  logic arst_n,
  input  logic srst,
  input  logic enable,
  input  logic stop_on_err,
  lut_checker_multi_if.slave bus
);
  localparam int WDD = WD + 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  localparam logic [WDD-1:0] TOL_V = WDD'(TOL);

  logic [1:0]            state_reg;
  logic                  v1_reg;
  logic                  has_data_reg;
  logic                  first_seen_reg;
  logic                  out_valid_reg;
  logic signed [WDD-1:0] delta1_reg [NCH];
  logic signed [WDD-1:0] min_reg [NCH];
  logic signed [WDD-1:0] max_reg [NCH];
  logic signed [WDD-1:0] delta_next [NCH];
  logic [WDD-1:0]        mag [NCH];
  logic [NCH-1:0]        war_next, err_next;
  logic [NCH-1:0]        war_reg, err_reg;
  logic [WCNT-1:0]       smp_cnt_reg, war_cnt_reg, err_cnt_reg, first_err_smp_reg;
  logic [WCH-1:0]        first_err_ch_reg, first_ch;
  logic                  beat_done, go_halt;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [WD-1:0] e_smp, r_smp;
      assign e_smp = bus.exp_data[gi*WD +: WD];
      assign r_smp = bus.res_data[gi*WD +: WD];
      // One extra bit makes the difference exact for any pair of WD-bit samples.
      assign delta_next[gi] = $signed({e_smp[WD-1], e_smp}) - $signed({r_smp[WD-1], r_smp});
      assign mag[gi] = delta1_reg[gi][WD] ? $unsigned(-delta1_reg[gi]) : $unsigned(delta1_reg[gi]);
      assign err_next[gi] = mag[gi] > TOL_V;
      assign war_next[gi] = (mag[gi] != '0) && (mag[gi] <= TOL_V);
      assign bus.min_delta[gi*WDD +: WDD] = min_reg[gi];
      assign bus.max_delta[gi*WDD +: WDD] = max_reg[gi];
    end
  endgenerate

  always_comb begin
    first_ch = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (err_next[c]) first_ch = WCH'(c);
    end
  end

  assign beat_done = v1_reg && (state_reg != ST_HALT);
  assign go_halt   = beat_done && stop_on_err && (|err_next);

  function automatic logic [WCNT-1:0] sat_inc(input logic [WCNT-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg         <= ST_IDLE;
      v1_reg            <= 1'b0;
      has_data_reg      <= 1'b0;
      first_seen_reg    <= 1'b0;
      out_valid_reg     <= 1'b0;
      delta1_reg        <= '{default: '0};
      min_reg           <= '{default: '0};
      max_reg           <= '{default: '0};
      war_reg           <= '0;
      err_reg           <= '0;
      smp_cnt_reg       <= '0;
      war_cnt_reg       <= '0;
      err_cnt_reg       <= '0;
      first_err_smp_reg <= '0;
      first_err_ch_reg  <= '0;
    end else if (srst) begin
      state_reg         <= ST_IDLE;
      v1_reg            <= 1'b0;
      has_data_reg      <= 1'b0;
      first_seen_reg    <= 1'b0;
      out_valid_reg     <= 1'b0;
      delta1_reg        <= '{default: '0};
      min_reg           <= '{default: '0};
      max_reg           <= '{default: '0};
      war_reg           <= '0;
      err_reg           <= '0;
      smp_cnt_reg       <= '0;
      war_cnt_reg       <= '0;
      err_cnt_reg       <= '0;
      first_err_smp_reg <= '0;
      first_err_ch_reg  <= '0;
    end else if (enable) begin
      // A beat entering stage 1 on the halting edge is dropped.
      v1_reg <= bus.in_valid && (state_reg != ST_HALT) && !go_halt;
      if (bus.in_valid && (state_reg != ST_HALT)) delta1_reg <= delta_next;
      out_valid_reg <= beat_done && !go_halt;
      if (beat_done) begin
        war_reg     <= war_next;
        err_reg     <= err_next;
        smp_cnt_reg <= sat_inc(smp_cnt_reg);
        if (|err_next)      err_cnt_reg <= sat_inc(err_cnt_reg);
        else if (|war_next) war_cnt_reg <= sat_inc(war_cnt_reg);
        if ((|err_next) && !first_seen_reg) begin
          first_seen_reg    <= 1'b1;
          first_err_ch_reg  <= first_ch;
          first_err_smp_reg <= smp_cnt_reg;
        end
        for (int c = 0; c < NCH; c++) begin
          if (!has_data_reg || (delta1_reg[c] < min_reg[c])) min_reg[c] <= delta1_reg[c];
          if (!has_data_reg || (delta1_reg[c] > max_reg[c])) max_reg[c] <= delta1_reg[c];
        end
        has_data_reg <= 1'b1;
        state_reg    <= go_halt ? ST_HALT : ST_RUN;
      end
    end
  end

  assign bus.out_valid     = out_valid_reg;
  assign bus.war           = war_reg;
  assign bus.err           = err_reg;
  assign bus.smp_cnt       = smp_cnt_reg;
  assign bus.war_cnt       = war_cnt_reg;
  assign bus.err_cnt       = err_cnt_reg;
  assign bus.first_err_ch  = first_err_ch_reg;
  assign bus.first_err_smp = first_err_smp_reg;
  assign bus.halted        = (state_reg == ST_HALT);
endmodule

// File: tb/tb_lut_checker_multi.sv
// Bench for lut_checker_multi: table-driven beats with a flag scoreboard plus hand-written
// sequences for latency, stall, asynchronous reset, stop-on-error, tolerance and saturation.
module tb_lut_checker_multi;
  localparam int WDD = 17;

  typedef struct {
    logic [63:0] e;
    logic [63:0] r;
    logic [3:0]  w;
    logic [3:0]  er;
  } vec_t;

  logic clk = 1'b0;
  logic arst_n = 1'b1;
  logic srst = 1'b0;
  logic enable = 1'b1;
  logic stop_on_err = 1'b0;
  logic en_last = 1'b1;
  logic [63:0] rnd;
  int checks = 0;
  int errors = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  vec_t tbl[6];

  lut_checker_multi_if #(.NCH(4), .WD(16), .WCNT(16)) bus_a ();
  lut_checker_multi_if #(.NCH(4), .WD(16), .WCNT(8))  bus_b ();

  lut_checker_multi #(.NCH(4), .WD(16), .TOL(1), .WCNT(16)) dut_a (
    .clk(clk), .arst_n(arst_n), .srst(srst), .enable(enable),
    .stop_on_err(stop_on_err), .bus(bus_a)
  );

  lut_checker_multi #(.NCH(4), .WD(16), .TOL(5), .WCNT(8)) dut_b (
    .clk(clk), .arst_n(arst_n), .srst(srst), .enable(enable),
    .stop_on_err(stop_on_err), .bus(bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) en_last <= enable;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [15:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [63:0] dv(input int v);
    logic [16:0] t;
    t = v[16:0];
    return {47'd0, t};
  endfunction

  function automatic logic [63:0] amin(input int c); return {47'd0, bus_a.min_delta[c*WDD +: WDD]}; endfunction
  function automatic logic [63:0] amax(input int c); return {47'd0, bus_a.max_delta[c*WDD +: WDD]}; endfunction
  function automatic logic [63:0] bmin(input int c); return {47'd0, bus_b.min_delta[c*WDD +: WDD]}; endfunction
  function automatic logic [63:0] bmax(input int c); return {47'd0, bus_b.max_delta[c*WDD +: WDD]}; endfunction

  task automatic beat_a(input logic [63:0] e, input logic [63:0] r, input logic [7:0] f, input bit push);
    bus_a.in_valid = 1'b1;
    bus_a.exp_data = e;
    bus_a.res_data = r;
    if (push) q_a.push_back(f);
  endtask

  task automatic beat_b(input logic [63:0] e, input logic [63:0] r, input logic [7:0] f, input bit push);
    bus_b.in_valid = 1'b1;
    bus_b.exp_data = e;
    bus_b.res_data = r;
    if (push) q_b.push_back(f);
  endtask

  task automatic idle(input int n);
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero_a(input string t);
    chk({t, "_out_valid"}, 64'(bus_a.out_valid), 64'd0);
    chk({t, "_flags"}, 64'({bus_a.war, bus_a.err}), 64'd0);
    chk({t, "_smp_cnt"}, 64'(bus_a.smp_cnt), 64'd0);
    chk({t, "_war_cnt"}, 64'(bus_a.war_cnt), 64'd0);
    chk({t, "_err_cnt"}, 64'(bus_a.err_cnt), 64'd0);
    chk({t, "_first_err_ch"}, 64'(bus_a.first_err_ch), 64'd0);
    chk({t, "_first_err_smp"}, 64'(bus_a.first_err_smp), 64'd0);
    chk({t, "_halted"}, 64'(bus_a.halted), 64'd0);
    chk({t, "_min_any"}, 64'(|bus_a.min_delta), 64'd0);
    chk({t, "_max_any"}, 64'(|bus_a.max_delta), 64'd0);
  endtask

  // Scoreboards: a beat counts only on an edge where the pipeline advanced.
  always @(negedge clk) begin
    if (arst_n && en_last && bus_a.out_valid) begin
      if (q_a.size() == 0) chk("a_unexpected_beat", 64'(bus_a.out_valid), 64'd0);
      else begin
        $display("beat a: war=%b err=%b smp_cnt=%0d", bus_a.war, bus_a.err, bus_a.smp_cnt);
        chk("a_flags", 64'({bus_a.war, bus_a.err}), 64'(q_a.pop_front()));
      end
    end
    if (arst_n && en_last && bus_b.out_valid) begin
      if (q_b.size() == 0) chk("b_unexpected_beat", 64'(bus_b.out_valid), 64'd0);
      else begin
        $display("beat b: war=%b err=%b smp_cnt=%0d", bus_b.war, bus_b.err, bus_b.smp_cnt);
        chk("b_flags", 64'({bus_b.war, bus_b.err}), 64'(q_b.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{pk(16'd100, 16'hFFFB, 16'd0, 16'h7FFF), pk(16'd100, 16'hFFFC, 16'd2, 16'h8000), 4'b0010, 4'b1100};
    tbl[1] = '{pk(16'd1, 16'd2, 16'd3, 16'd4), pk(16'd1, 16'd2, 16'd3, 16'd4), 4'b0000, 4'b0000};
    tbl[2] = '{pk(16'd5, 16'd0, 16'd0, 16'd0), pk(16'd4, 16'd0, 16'd0, 16'd1), 4'b1001, 4'b0000};
    tbl[3] = '{pk(16'd0, 16'd10, 16'd0, 16'd0), pk(16'd0, 16'd8, 16'd0, 16'd0), 4'b0000, 4'b0010};
    tbl[4] = '{pk(16'h8000, 16'd0, 16'd0, 16'd0), pk(16'h7FFF, 16'd0, 16'd0, 16'd0), 4'b0000, 4'b0001};
    tbl[5] = '{pk(16'd1, 16'd1, 16'd1, 16'd1), pk(16'd0, 16'd0, 16'd0, 16'd0), 4'b1111, 4'b0000};
    bus_a.in_valid = 1'b0; bus_a.exp_data = '0; bus_a.res_data = '0;
    bus_b.in_valid = 1'b0; bus_b.exp_data = '0; bus_b.res_data = '0;

    #2 arst_n = 1'b0;
    #1 chk_zero_a("reset");
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    // Mixed beat: check latency and first-error capture.
    @(negedge clk); beat_a(tbl[0].e, tbl[0].r, {tbl[0].w, tbl[0].er}, 1'b1);
    @(negedge clk); idle(0);
    chk("latency_not_early", 64'(bus_a.out_valid), 64'd0);
    @(negedge clk);
    chk("t0_out_valid", 64'(bus_a.out_valid), 64'd1);
    chk("t0_smp_cnt", 64'(bus_a.smp_cnt), 64'd1);
    chk("t0_err_cnt", 64'(bus_a.err_cnt), 64'd1);
    chk("t0_war_cnt", 64'(bus_a.war_cnt), 64'd0);
    chk("t0_first_err_ch", 64'(bus_a.first_err_ch), 64'd2);
    chk("t0_first_err_smp", 64'(bus_a.first_err_smp), 64'd0);
    chk("t0_max3", amax(3), dv(65535));
    chk("t0_min2", amin(2), dv(-2));
    chk("t0_min1", amin(1), dv(-1));

    for (int i = 1; i < 6; i++) begin
      @(negedge clk); beat_a(tbl[i].e, tbl[i].r, {tbl[i].w, tbl[i].er}, 1'b1);
    end
    @(negedge clk); idle(2);
    chk("tbl_smp_cnt", 64'(bus_a.smp_cnt), 64'd6);
    chk("tbl_err_cnt", 64'(bus_a.err_cnt), 64'd3);
    chk("tbl_war_cnt", 64'(bus_a.war_cnt), 64'd2);
    chk("tbl_first_err_ch", 64'(bus_a.first_err_ch), 64'd2);
    chk("tbl_min0", amin(0), dv(-65535));
    chk("tbl_max0", amax(0), dv(1));
    chk("tbl_min3", amin(3), dv(-1));
    chk("tbl_max3", amax(3), dv(65535));

    // Three-cycle stall between two beats.
    @(negedge clk); beat_a(pk(16'd9, 16'd9, 16'd9, 16'd9), pk(16'd9, 16'd9, 16'd9, 16'd9), 8'h00, 1'b1);
    @(negedge clk); bus_a.in_valid = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_smp_cnt", 64'(bus_a.smp_cnt), 64'd6);
    chk("stall_out_valid", 64'(bus_a.out_valid), 64'd0);
    @(negedge clk); enable = 1'b1;
    beat_a(pk(16'd0, 16'd0, 16'd1, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0), {4'b0100, 4'b0000}, 1'b1);
    @(negedge clk); idle(2);
    chk("stall_after_smp_cnt", 64'(bus_a.smp_cnt), 64'd8);
    chk("stall_after_war_cnt", 64'(bus_a.war_cnt), 64'd3);

    // Asynchronous reset with two beats in flight.
    @(negedge clk); beat_a(pk(16'd7, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0), 8'h01, 1'b1);
    @(negedge clk); beat_a(pk(16'd0, 16'd3, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0), 8'h02, 1'b1);
    #1 arst_n = 1'b0; q_a.delete();
    #1 chk_zero_a("arst_mid");
    @(negedge clk); idle(0); arst_n = 1'b1;
    @(negedge clk); beat_a(pk(16'd0, 16'd0, 16'd0, 16'd0), pk(16'd3, 16'd0, 16'd0, 16'd0), 8'h01, 1'b1);
    @(negedge clk); idle(2);
    chk("post_arst_smp_cnt", 64'(bus_a.smp_cnt), 64'd1);
    chk("post_arst_first_err_ch", 64'(bus_a.first_err_ch), 64'd0);
    chk("post_arst_min0", amin(0), dv(-3));
    chk("post_arst_max0", amax(0), dv(-3));

    // Stop-on-error: error at beat 5, four more beats behind it.
    @(negedge clk); srst = 1'b1;
    @(negedge clk); srst = 1'b0;
    chk_zero_a("srst1");
    stop_on_err = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 6) chk("halt_not_early", 64'(bus_a.halted), 64'd0);
      if (i == 7) chk("halt_two_cycles", 64'(bus_a.halted), 64'd1);
      if (i < 5) beat_a(pk(16'(i), 16'(i), 16'(i), 16'(i)), pk(16'(i), 16'(i), 16'(i), 16'(i)), 8'h00, 1'b1);
      else if (i == 5) beat_a(pk(16'd0, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd1, 16'd0, 16'd9), 8'h00, 1'b0);
      else beat_a(pk(16'd0, 16'd0, 16'd0, 16'd0), pk(16'd5, 16'd5, 16'd5, 16'd5), 8'h00, 1'b0);
    end
    @(negedge clk); idle(3);
    chk("halt_halted", 64'(bus_a.halted), 64'd1);
    chk("halt_smp_cnt", 64'(bus_a.smp_cnt), 64'd6);
    chk("halt_err_cnt", 64'(bus_a.err_cnt), 64'd1);
    chk("halt_war_cnt", 64'(bus_a.war_cnt), 64'd0);
    chk("halt_first_err_ch", 64'(bus_a.first_err_ch), 64'd3);
    chk("halt_first_err_smp", 64'(bus_a.first_err_smp), 64'd5);
    chk("halt_flags", 64'({bus_a.war, bus_a.err}), 64'({4'b0010, 4'b1000}));
    chk("halt_out_valid", 64'(bus_a.out_valid), 64'd0);
    @(negedge clk); srst = 1'b1; stop_on_err = 1'b0;
    @(negedge clk); srst = 1'b0;
    chk_zero_a("srst_halt");

    // TOL=5 instance: running min/max and tolerance boundary.
    @(negedge clk); beat_b(pk(16'd3, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0), 8'h10, 1'b1);
    @(negedge clk); beat_b(pk(16'd0, 16'd0, 16'd0, 16'd0), pk(16'd2, 16'd0, 16'd0, 16'd0), 8'h10, 1'b1);
    @(negedge clk);
    chk("b_min_first", bmin(0), dv(3));
    chk("b_max_first", bmax(0), dv(3));
    beat_b(pk(16'd1, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0), 8'h10, 1'b1);
    @(negedge clk); beat_b(pk(16'd0, 16'd5, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0), 8'h20, 1'b1);
    @(negedge clk); beat_b(pk(16'd0, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd6, 16'd0), 8'h04, 1'b1);
    @(negedge clk); idle(2);
    chk("b_min0", bmin(0), dv(-2));
    chk("b_max0", bmax(0), dv(3));
    chk("b_max1", bmax(1), dv(5));
    chk("b_min2", bmin(2), dv(-6));
    chk("b_war_cnt", 64'(bus_b.war_cnt), 64'd4);
    chk("b_err_cnt", 64'(bus_b.err_cnt), 64'd1);
    chk("b_smp_cnt", 64'(bus_b.smp_cnt), 64'd5);

    // 300 matching beats into an 8-bit counter.
    @(negedge clk); srst = 1'b1;
    @(negedge clk); srst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rnd = {$urandom, $urandom};
      @(negedge clk); beat_b(rnd, rnd, 8'h00, 1'b1);
    end
    @(negedge clk); idle(3);
    chk("sat_smp_cnt", 64'(bus_b.smp_cnt), 64'd255);
    chk("sat_war_cnt", 64'(bus_b.war_cnt), 64'd0);
    chk("sat_err_cnt", 64'(bus_b.err_cnt), 64'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("sat_min%0d", c), bmin(c), dv(0));
      chk($sformatf("sat_max%0d", c), bmax(c), dv(0));
    end

    chk("a_queue_drained", 64'(q_a.size()), 64'd0);
    chk("b_queue_drained", 64'(q_b.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
